// File: rtl/pipe_test_pkg.sv
// rtl/pipe_test_pkg.sv - shared pipe-test types, constants and LFSR step
// Used by the transmit source and by pipe_in_check so both agree on the sequence.
package pipe_test_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      READY = 2'd1,
      XFER  = 2'd2
   } pipe_state_t;

   // Taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0)
   localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0D0C_0B0A;
   localparam logic [15:0] COUNTER_START     = 16'h0001;

   function automatic logic [31:0] next_lfsr(input logic [31:0] cur);
      return {cur[30:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/pipe_out_prbs_source_if.sv
// rtl/pipe_out_prbs_source_if.sv - block-throttled pipe-out endpoint bus
// master = host side, slave = data source.
interface pipe_out_prbs_source_if #(
   parameter int DATA_W = 16
);
   logic              ep_blockstrobe;
   logic              ep_read;
   logic [DATA_W-1:0] ep_datain;
   logic              ep_ready;

   modport master (
      output ep_blockstrobe,
      output ep_read,
      input  ep_datain,
      input  ep_ready
   );

   modport slave (
      input  ep_blockstrobe,
      input  ep_read,
      output ep_datain,
      output ep_ready
   );
endinterface

// File: rtl/pipe_prbs_gen.sv
// rtl/pipe_prbs_gen.sv - counter / Fibonacci LFSR test-word generator
// Only the sequence selected by mode steps on advance, so each stays contiguous.
module pipe_prbs_gen
   import pipe_test_pkg::*;
#(
   parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   input  logic        mode,
   output logic [15:0] data
);

   logic [31:0] lfsr;
   logic [15:0] counter;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr    <= LFSR_SEED;
         counter <= COUNTER_START;
      end else if (advance) begin
         if (mode) begin
            lfsr <= next_lfsr(lfsr);
         end else begin
            counter <= counter + 16'd1;
         end
      end
   end

   assign data = mode ? lfsr[15:0] : counter;

endmodule

// File: rtl/pipe_out_prbs_source.sv
// rtl/pipe_out_prbs_source.sv - pipe-out test source: generator, FIFO, block FSM
// Optional PIPE_OUT_STATS_EN adds words_sent / blocks_sent counters.
module pipe_out_prbs_source
   import pipe_test_pkg::*;
#(
   parameter int          DATA_W      = 16,
   parameter int          BLOCK_WORDS = 256,
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
   input  logic                 ti_clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 mode,
   pipe_out_prbs_source_if.slave ep,
   output logic                 underflow,
   output logic                 proto_err
`ifdef PIPE_OUT_STATS_EN
   ,
   output logic [31:0]          words_sent,
   output logic [15:0]          blocks_sent
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = $clog2(BLOCK_WORDS);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] BLOCK_CNT = CW'(BLOCK_WORDS);
   localparam logic [RW-1:0] RD_LAST   = RW'(BLOCK_WORDS - 1);

   // Assert follows reset_n immediately; release is retimed onto ti_clk.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge ti_clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   logic [15:0] gen_data;
   logic        push;
   logic        pop;

   pipe_prbs_gen #(
      .LFSR_SEED(LFSR_SEED)
   ) u_gen (
      .clk    (ti_clk),
      .rst_n  (rst_n),
      .advance(push),
      .mode   (mode),
      .data   (gen_data)
   );

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   assign push = enable && (count != DEPTH_CNT);
   assign pop  = ep.ep_read && (count != '0);

   always_ff @(posedge ti_clk) begin
      if (push) begin
         mem[wr_ptr] <= gen_data;
      end
   end

   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         ep.ep_datain <= '0;
         underflow    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr       <= rd_ptr + 1'b1;
            ep.ep_datain <= mem[rd_ptr];
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (ep.ep_read && (count == '0)) begin
            underflow <= 1'b1;
         end
      end
   end

   pipe_state_t   state;
   pipe_state_t   state_d;
   logic [RW-1:0] rd_cnt;
   logic          ready_d;
   logic          proto_set;
   logic          rd_clr;
   logic          rd_inc;

   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_d;
      end
   end

   // A strobe inside XFER restarts the block, so it never completes that cycle.
   always_comb begin
      state_d = state;
      case (state)
         FILL:    if (count >= BLOCK_CNT) state_d = READY;
         READY:   if (ep.ep_blockstrobe) state_d = XFER;
         XFER:    if (!ep.ep_blockstrobe && ep.ep_read && (rd_cnt == RD_LAST)) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      ready_d   = (state_d == READY);
      proto_set = ep.ep_blockstrobe && (state != READY);
      rd_clr    = ep.ep_blockstrobe;
      rd_inc    = (state == XFER) && ep.ep_read;
   end

   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         ep.ep_ready <= 1'b0;
         proto_err   <= 1'b0;
         rd_cnt      <= '0;
      end else begin
         ep.ep_ready <= ready_d;
         if (proto_set) begin
            proto_err <= 1'b1;
         end
         if (rd_clr) begin
            rd_cnt <= '0;
         end else if (rd_inc) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
      end
   end

`ifdef PIPE_OUT_STATS_EN
   logic block_done;

   assign block_done = (state == XFER) && (state_d == FILL);

   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         words_sent  <= '0;
         blocks_sent <= '0;
      end else begin
         if (pop) begin
            words_sent <= words_sent + 32'd1;
         end
         if (block_done) begin
            blocks_sent <= blocks_sent + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_out_prbs_source.sv
// tb/tb_pipe_out_prbs_source.sv - directed bench for pipe_out_prbs_source
// Vector table for single-cycle behaviour plus block-level sequences.
module tb_pipe_out_prbs_source;

   logic ti_clk = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;
   logic mode = 1'b0;
   logic underflow;
   logic proto_err;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [15:0] cnt_model;
   logic [31:0] lfsr_model;

   always #5 ti_clk = ~ti_clk;

   pipe_out_prbs_source_if #(.DATA_W(16)) ep_bus ();

`ifdef PIPE_OUT_STATS_EN
   logic [31:0] words_sent;
   logic [15:0] blocks_sent;
`endif

   pipe_out_prbs_source dut (
      .ti_clk     (ti_clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .mode       (mode),
      .ep         (ep_bus),
      .underflow  (underflow),
      .proto_err  (proto_err)
`ifdef PIPE_OUT_STATS_EN
      ,
      .words_sent (words_sent),
      .blocks_sent(blocks_sent)
`endif
   );

   typedef struct packed {
      logic        en;
      logic        md;
      logic        bs;
      logic        rd;
      logic [15:0] dat;
      logic        rdy;
      logic        uf;
      logic        pe;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [31:0] model_lfsr(input logic [31:0] s);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {s[30:0], fb};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      ep_bus.ep_read = 1'b0;
      ep_bus.ep_blockstrobe = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge ti_clk);
      reset_n = 1'b1;
      repeat (3) @(negedge ti_clk);
      cnt_model  = 16'h0001;
      lfsr_model = 32'h0D0C0B0A;
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (!ep_bus.ep_ready && k < 4000) begin
         @(negedge ti_clk);
         k++;
      end
      check("ready_wait", {31'd0, ep_bus.ep_ready}, 32'd1);
   endtask

   task automatic read_block(input int n, input logic use_lfsr);
      logic [15:0] exp;
      ep_bus.ep_blockstrobe = 1'b1;
      @(negedge ti_clk);
      ep_bus.ep_blockstrobe = 1'b0;
      ep_bus.ep_read = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge ti_clk);
         if (i == n - 1) ep_bus.ep_read = 1'b0;
         if (use_lfsr) begin
            exp = lfsr_model[15:0];
            lfsr_model = model_lfsr(lfsr_model);
         end else begin
            exp = cnt_model;
            cnt_model = cnt_model + 16'd1;
         end
         check($sformatf("word%0d", i), {16'd0, ep_bus.ep_datain}, {16'd0, exp});
         if (i == 0 || i == n - 1)
            check($sformatf("ready_low_xfer%0d", i), {31'd0, ep_bus.ep_ready}, 32'd0);
      end
   endtask

   initial begin
      ep_bus.ep_read = 1'b0;
      ep_bus.ep_blockstrobe = 1'b0;

      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0B0A, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0B0A, 1'b0, 1'b1, 1'b1};

      // Reset state, underflow, proto_err in FILL, simultaneous push/pop
      do_reset();
      for (int i = 0; i < 9; i++) begin
         enable = tbl[i].en;
         mode = tbl[i].md;
         ep_bus.ep_blockstrobe = tbl[i].bs;
         ep_bus.ep_read = tbl[i].rd;
         @(negedge ti_clk);
         check($sformatf("vec%0d_dat", i), {16'd0, ep_bus.ep_datain}, {16'd0, tbl[i].dat});
         check($sformatf("vec%0d_rdy", i), {31'd0, ep_bus.ep_ready}, {31'd0, tbl[i].rdy});
         check($sformatf("vec%0d_uf", i), {31'd0, underflow}, {31'd0, tbl[i].uf});
         check($sformatf("vec%0d_pe", i), {31'd0, proto_err}, {31'd0, tbl[i].pe});
      end
      enable = 1'b0;
      ep_bus.ep_blockstrobe = 1'b0;
      ep_bus.ep_read = 1'b0;

      // Counter block
      mode = 1'b0;
      do_reset();
      enable = 1'b1;
      wait_ready();
      read_block(256, 1'b0);
      check("t1_underflow", {31'd0, underflow}, 32'd0);
      check("t1_proto_err", {31'd0, proto_err}, 32'd0);
`ifdef PIPE_OUT_STATS_EN
      check("t1_words_sent", words_sent, 32'd256);
      check("t1_blocks_sent", {16'd0, blocks_sent}, 32'd1);
`endif

      // Four LFSR blocks back to back
      enable = 1'b0;
      mode = 1'b1;
      do_reset();
      enable = 1'b1;
      for (int b = 0; b < 4; b++) begin
         wait_ready();
         read_block(256, 1'b1);
      end
      check("t2_underflow", {31'd0, underflow}, 32'd0);
      check("t2_proto_err", {31'd0, proto_err}, 32'd0);

      // Fill to full, then drain exactly DEPTH words
      enable = 1'b0;
      mode = 1'b0;
      do_reset();
      enable = 1'b1;
      repeat (2000) @(negedge ti_clk);
      check("t5_ready_full", {31'd0, ep_bus.ep_ready}, 32'd1);
      enable = 1'b0;
      ep_bus.ep_read = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         @(negedge ti_clk);
         check($sformatf("full_word%0d", i), {16'd0, ep_bus.ep_datain}, {16'd0, cnt_model});
         cnt_model = cnt_model + 16'd1;
      end
      check("t5_no_uf_yet", {31'd0, underflow}, 32'd0);
      @(negedge ti_clk);
      ep_bus.ep_read = 1'b0;
      check("t5_uf_after_drain", {31'd0, underflow}, 32'd1);
      check("t5_hold", {16'd0, ep_bus.ep_datain}, 32'h0000_0400);

      // Reset in the middle of a block
      do_reset();
      enable = 1'b1;
      wait_ready();
      read_block(100, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check("t6_dat_zero", {16'd0, ep_bus.ep_datain}, 32'd0);
      check("t6_rdy_zero", {31'd0, ep_bus.ep_ready}, 32'd0);
      check("t6_uf_zero", {31'd0, underflow}, 32'd0);
      check("t6_pe_zero", {31'd0, proto_err}, 32'd0);
      @(negedge ti_clk);
      do_reset();
      wait_ready();
      read_block(4, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
